// File: rtl/upsample_reader.sv
// Frame buffer read side: walks a SRC_W x SRC_H grayscale buffer under display
// timing and pixel/line-doubles it into a 2*SRC_W x 2*SRC_H stream.
module upsample_reader #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int RD_LAT = 2
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iFRAME_START,
    input  logic        iACTIVE,
    input  logic [7:0]  iRDATA,
    output logic [16:0] oADDR,
    output logic        oRDEN,
    output logic [7:0]  oGRAY,
    output logic        oVALID,
    output logic        oFRAME_DONE,
    output logic        oERR
);
    localparam logic [9:0]  XMAX     = 10'(2 * SRC_W);
    localparam logic [8:0]  YLAST    = 9'(2 * SRC_H - 1);
    localparam logic [16:0] ROW_STEP = 17'(SRC_W);
    localparam logic [8:0]  XH_MAX   = 9'(SRC_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state, state_nxt;
    logic [9:0]        xcnt, xcnt_nxt;
    logic [8:0]        ycnt, ycnt_nxt;
    logic [16:0]       row_base, row_base_nxt;
    logic              active_d;
    logic              ovr_seen, ovr_seen_nxt;
    logic              err_nxt, done_nxt;
    logic              line_end, x_full;
    logic [8:0]        xh;
    logic              vld_p0, rd_p0;
    logic [RD_LAT-1:0] vld_p, rd_p;

    assign x_full   = (xcnt == XMAX);
    assign line_end = active_d && !iACTIVE;
    // Clamp the column at the saturated count so the address never leaves the buffer.
    assign xh       = x_full ? XH_MAX : xcnt[9:1];
    assign oADDR    = row_base + {8'd0, xh};
    assign oRDEN    = (state == ACTIVE) && iACTIVE && (xcnt < XMAX);

    assign vld_p0   = (state == ACTIVE) && iACTIVE;
    assign rd_p0    = oRDEN;

    always_comb begin
        state_nxt    = state;
        xcnt_nxt     = xcnt;
        ycnt_nxt     = ycnt;
        row_base_nxt = row_base;
        ovr_seen_nxt = ovr_seen;
        err_nxt      = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (iFRAME_START) begin
                    state_nxt    = ACTIVE;
                    xcnt_nxt     = '0;
                    ycnt_nxt     = '0;
                    row_base_nxt = '0;
                    ovr_seen_nxt = 1'b0;
                end
            end
            ACTIVE: begin
                if (iACTIVE && (xcnt < XMAX))
                    xcnt_nxt = xcnt + 10'd1;
                if (iACTIVE && x_full && !ovr_seen) begin
                    err_nxt      = 1'b1;
                    ovr_seen_nxt = 1'b1;
                end
                if (line_end) begin
                    xcnt_nxt     = '0;
                    ycnt_nxt     = ycnt + 9'd1;
                    ovr_seen_nxt = 1'b0;
                    if (!x_full)
                        err_nxt = 1'b1;
                    if (ycnt[0])
                        row_base_nxt = row_base + ROW_STEP;
                    if (ycnt == YLAST) begin
                        state_nxt    = IDLE;
                        done_nxt     = 1'b1;
                        ycnt_nxt     = '0;
                        row_base_nxt = '0;
                    end
                end
                // Resync overrides any line-end bookkeeping of the same cycle.
                if (iFRAME_START) begin
                    state_nxt    = ACTIVE;
                    xcnt_nxt     = '0;
                    ycnt_nxt     = '0;
                    row_base_nxt = '0;
                    ovr_seen_nxt = 1'b0;
                    done_nxt     = 1'b0;
                    if ((xcnt != 10'd0) || (ycnt != 9'd0))
                        err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state       <= IDLE;
            xcnt        <= '0;
            ycnt        <= '0;
            row_base    <= '0;
            active_d    <= 1'b0;
            ovr_seen    <= 1'b0;
            oERR        <= 1'b0;
            oFRAME_DONE <= 1'b0;
            vld_p       <= '0;
            rd_p        <= '0;
        end else begin
            state       <= state_nxt;
            xcnt        <= xcnt_nxt;
            ycnt        <= ycnt_nxt;
            row_base    <= row_base_nxt;
            active_d    <= iACTIVE;
            ovr_seen    <= ovr_seen_nxt;
            oERR        <= err_nxt;
            oFRAME_DONE <= done_nxt;
            // Stage p0 -> p1..pRD_LAT: request flags ride alongside the buffer latency
            vld_p[0]    <= vld_p0;
            rd_p[0]     <= rd_p0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                rd_p[i]  <= rd_p[i-1];
            end
        end
    end

    // Output stage: data returns from the buffer aligned with the last flag stage
    assign oVALID = vld_p[RD_LAT-1];
    assign oGRAY  = rd_p[RD_LAT-1] ? iRDATA : 8'd0;

endmodule

// File: tb/tb_upsample_reader.sv
// Directed bench for upsample_reader: full-size geometry at RD_LAT 1/2/4 for
// line-level behaviour, plus a small geometry for whole-frame and resync cases.
module tb_upsample_reader;
    localparam int AX = 640;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, fs_a, act_a, fs_b, act_b;
    logic [16:0] a_addr, c_addr, d_addr, b_addr;
    logic [7:0]  a_rdata, c_rdata, d_rdata, b_rdata;
    logic [7:0]  a_gray, c_gray, d_gray, b_gray;
    logic a_rden, a_valid, a_done, a_err;
    logic c_rden, c_valid, c_done, c_err;
    logic d_rden, d_valid, d_done, d_err;
    logic b_rden, b_valid, b_done, b_err;

    int n_tests = 0;
    int n_fail  = 0;
    int bmax;
    logic [7:0] first4 [4];

    upsample_reader #(.SRC_W(320), .SRC_H(240), .RD_LAT(2)) ua (
        .iCLK(clk), .iRESET(rst), .iFRAME_START(fs_a), .iACTIVE(act_a), .iRDATA(a_rdata),
        .oADDR(a_addr), .oRDEN(a_rden), .oGRAY(a_gray), .oVALID(a_valid),
        .oFRAME_DONE(a_done), .oERR(a_err));
    upsample_reader #(.SRC_W(320), .SRC_H(240), .RD_LAT(1)) uc (
        .iCLK(clk), .iRESET(rst), .iFRAME_START(fs_a), .iACTIVE(act_a), .iRDATA(c_rdata),
        .oADDR(c_addr), .oRDEN(c_rden), .oGRAY(c_gray), .oVALID(c_valid),
        .oFRAME_DONE(c_done), .oERR(c_err));
    upsample_reader #(.SRC_W(320), .SRC_H(240), .RD_LAT(4)) ud (
        .iCLK(clk), .iRESET(rst), .iFRAME_START(fs_a), .iACTIVE(act_a), .iRDATA(d_rdata),
        .oADDR(d_addr), .oRDEN(d_rden), .oGRAY(d_gray), .oVALID(d_valid),
        .oFRAME_DONE(d_done), .oERR(d_err));
    upsample_reader #(.SRC_W(4), .SRC_H(60), .RD_LAT(2)) ub (
        .iCLK(clk), .iRESET(rst), .iFRAME_START(fs_b), .iACTIVE(act_b), .iRDATA(b_rdata),
        .oADDR(b_addr), .oRDEN(b_rden), .oGRAY(b_gray), .oVALID(b_valid),
        .oFRAME_DONE(b_done), .oERR(b_err));

    // Buffer models: word content is addr[7:0], returned after the instance's latency
    logic [16:0] a_mp [2];
    logic [16:0] c_mp [1];
    logic [16:0] d_mp [4];
    logic [16:0] b_mp [2];
    always @(posedge clk) begin
        a_mp[0] <= a_addr; a_mp[1] <= a_mp[0];
        c_mp[0] <= c_addr;
        d_mp[0] <= d_addr; d_mp[1] <= d_mp[0]; d_mp[2] <= d_mp[1]; d_mp[3] <= d_mp[2];
        b_mp[0] <= b_addr; b_mp[1] <= b_mp[0];
    end
    assign a_rdata = a_mp[1][7:0];
    assign c_rdata = c_mp[0][7:0];
    assign d_rdata = d_mp[3][7:0];
    assign b_rdata = b_mp[1][7:0];

    function automatic logic ev(int i, int len, int lat);
        int j = i - lat;
        return (j >= 0) && (j < len);
    endfunction

    function automatic logic [7:0] eg(int i, int len, int lat, int base);
        int j = i - lat;
        if (j >= 0 && j < len && j < AX) return 8'(base + j / 2);
        return 8'd0;
    endfunction

    task automatic line_a(input int len, input int gap, input int base,
                          output int abad, output int vb2, output int vb1, output int vb4,
                          output int nerr, output int err_at, output int ndone, output int rdlow);
        logic exp_rd;
        abad = 0; vb2 = 0; vb1 = 0; vb4 = 0; nerr = 0; err_at = -1; ndone = 0; rdlow = 0;
        for (int i = 0; i < len + gap; i++) begin
            act_a = (i < len);
            @(negedge clk);
            exp_rd = (i < len) && (i < AX);
            if (a_rden !== exp_rd) abad++;
            else if (exp_rd && a_addr !== 17'(base + i / 2)) abad++;
            if ((i < len) && (a_rden === 1'b0)) rdlow++;
            if (a_valid !== ev(i, len, 2) || a_gray !== eg(i, len, 2, base)) vb2++;
            if (c_valid !== ev(i, len, 1) || c_gray !== eg(i, len, 1, base)) vb1++;
            if (d_valid !== ev(i, len, 4) || d_gray !== eg(i, len, 4, base)) vb4++;
            if (a_err === 1'b1) begin nerr++; if (err_at < 0) err_at = i; end
            if (a_done === 1'b1) ndone++;
            if (i >= 2 && i < 6) first4[i-2] = a_gray;
            @(posedge clk); #1;
        end
    endtask

    task automatic line_b(input int len, input int gap, input int base, input int fs_at,
                          output int abad, output int nerr, output int err_at,
                          output int ndone, output int done_at);
        logic exp_rd;
        int   exp_addr;
        abad = 0; nerr = 0; err_at = -1; ndone = 0; done_at = -1;
        for (int i = 0; i < len + gap; i++) begin
            act_b = (i < len);
            fs_b  = (i == fs_at);
            @(negedge clk);
            exp_rd   = (i < len) && (i < 8);
            exp_addr = (fs_at >= 0 && i > fs_at) ? (i - fs_at - 1) / 2 : base + i / 2;
            if (b_rden !== exp_rd) abad++;
            else if (exp_rd && b_addr !== 17'(exp_addr)) abad++;
            if (b_rden === 1'b1 && int'(b_addr) > bmax) bmax = int'(b_addr);
            if (b_err === 1'b1) begin nerr++; if (err_at < 0) err_at = i; end
            if (b_done === 1'b1) begin ndone++; if (done_at < 0) done_at = i; end
            @(posedge clk); #1;
        end
        fs_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fs_a = 1'b0; act_a = 1'b0; fs_b = 1'b0; act_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_addr !== 17'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", a_addr); end
        n_tests++;
        if ({a_rden, a_valid, a_done, a_err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {a_rden, a_valid, a_done, a_err});
        end
        n_tests++;
        if (a_gray !== 8'd0) begin n_fail++; $display("FAIL reset_gray: got %0d want 0", a_gray); end
        n_tests++;
        if ({c_valid, d_valid, b_valid, b_rden} !== 4'b0) begin
            n_fail++; $display("FAIL reset_others: got %b want 0000", {c_valid, d_valid, b_valid, b_rden});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_idle_active();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            act_a = (i < 5);
            act_b = (i < 5);
            @(negedge clk);
            if ({a_rden, a_valid, c_valid, d_valid, b_rden, b_valid, a_err} !== 7'b0) bad++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL idle_ignores_active: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_frame_a();
        int abad, vb2, vb1, vb4, nerr, err_at, ndone, rdlow, len, exp_err, exp_at, exp_low;
        fs_a = 1'b1; act_a = 1'b0;
        @(posedge clk); #1;
        fs_a = 1'b0;
        for (int k = 0; k < 9; k++) begin
            len     = (k == 5) ? 600 : (k == 7) ? 650 : 640;
            exp_err = (k == 5 || k == 7) ? 1 : 0;
            exp_at  = (k == 5) ? 601 : (k == 7) ? 641 : -1;
            exp_low = (k == 7) ? 10 : 0;
            line_a(len, 8, 320 * (k / 2), abad, vb2, vb1, vb4, nerr, err_at, ndone, rdlow);
            n_tests++;
            if (abad !== 0) begin n_fail++; $display("FAIL line%0d_addr: got %0d bad cycles want 0", k, abad); end
            n_tests++;
            if (vb2 !== 0) begin n_fail++; $display("FAIL line%0d_out_lat2: got %0d bad cycles want 0", k, vb2); end
            n_tests++;
            if (vb1 !== 0) begin n_fail++; $display("FAIL line%0d_out_lat1: got %0d bad cycles want 0", k, vb1); end
            n_tests++;
            if (vb4 !== 0) begin n_fail++; $display("FAIL line%0d_out_lat4: got %0d bad cycles want 0", k, vb4); end
            n_tests++;
            if (nerr !== exp_err || err_at !== exp_at) begin
                n_fail++; $display("FAIL line%0d_err: got %0d pulses at %0d want %0d at %0d", k, nerr, err_at, exp_err, exp_at);
            end
            n_tests++;
            if (rdlow !== exp_low) begin n_fail++; $display("FAIL line%0d_rden_low: got %0d want %0d", k, rdlow, exp_low); end
            n_tests++;
            if (ndone !== 0) begin n_fail++; $display("FAIL line%0d_done: got %0d want 0", k, ndone); end
            if (k == 2) begin
                n_tests++;
                if (first4[0] !== 8'd64 || first4[1] !== 8'd64 || first4[2] !== 8'd65 || first4[3] !== 8'd65) begin
                    n_fail++;
                    $display("FAIL line2_first_gray: got %0d,%0d,%0d,%0d want 64,64,65,65",
                             first4[0], first4[1], first4[2], first4[3]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        act_a = 1'b1;
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({a_valid, c_valid, d_valid} !== 3'b0) begin
            n_fail++; $display("FAIL rst_mid_valid: got %b want 000", {a_valid, c_valid, d_valid});
        end
        n_tests++;
        if (a_addr !== 17'd0) begin n_fail++; $display("FAIL rst_mid_addr: got %0d want 0", a_addr); end
        n_tests++;
        if (a_rden !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle_rden: got %b want 0", a_rden); end
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({a_rden, a_valid, c_valid, d_valid, a_gray, d_gray} !== 20'b0) bad++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_drain: got %0d bad cycles want 0", bad); end
        act_a = 1'b0;
    endtask

    task automatic test_full_frame_b();
        int abad, nerr, err_at, ndone, done_at, tabad, terr, tdone, last_done_at, bad;
        tabad = 0; terr = 0; tdone = 0; last_done_at = -1; bmax = 0; bad = 0;
        fs_b = 1'b1; act_b = 1'b0;
        @(posedge clk); #1;
        fs_b = 1'b0;
        for (int k = 0; k < 120; k++) begin
            line_b(8, 4, 4 * (k / 2), -1, abad, nerr, err_at, ndone, done_at);
            tabad += abad; terr += nerr; tdone += ndone;
            if (k == 119) last_done_at = done_at;
        end
        n_tests++;
        if (tabad !== 0) begin n_fail++; $display("FAIL frame_addr: got %0d bad cycles want 0", tabad); end
        n_tests++;
        if (terr !== 0) begin n_fail++; $display("FAIL frame_err: got %0d pulses want 0", terr); end
        n_tests++;
        if (tdone !== 1 || last_done_at !== 9) begin
            n_fail++; $display("FAIL frame_done: got %0d pulses at %0d want 1 at 9", tdone, last_done_at);
        end
        n_tests++;
        if (bmax !== 239) begin n_fail++; $display("FAIL frame_max_addr: got %0d want 239", bmax); end
        for (int i = 0; i < 3; i++) begin
            act_b = 1'b1;
            @(negedge clk);
            if (b_rden !== 1'b0 || b_addr !== 17'd0) bad++;
            @(posedge clk); #1;
        end
        act_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL frame_then_idle: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_resync_b();
        int abad, nerr, err_at, ndone, done_at, tabad, terr;
        tabad = 0; terr = 0;
        fs_b = 1'b1; act_b = 1'b0;
        @(posedge clk); #1;
        fs_b = 1'b0;
        for (int k = 0; k < 100; k++) begin
            line_b(8, 4, 4 * (k / 2), -1, abad, nerr, err_at, ndone, done_at);
            tabad += abad; terr += nerr;
        end
        n_tests++;
        if (tabad !== 0 || terr !== 0) begin
            n_fail++; $display("FAIL resync_lead_in: got %0d bad addr %0d err want 0 0", tabad, terr);
        end
        line_b(8, 4, 200, 3, abad, nerr, err_at, ndone, done_at);
        n_tests++;
        if (abad !== 0) begin n_fail++; $display("FAIL resync_line100_addr: got %0d bad cycles want 0", abad); end
        n_tests++;
        if (nerr !== 2 || err_at !== 4) begin
            n_fail++; $display("FAIL resync_line100_err: got %0d pulses at %0d want 2 at 4", nerr, err_at);
        end
        line_b(8, 4, 0, -1, abad, nerr, err_at, ndone, done_at);
        n_tests++;
        if (abad !== 0 || nerr !== 0) begin
            n_fail++; $display("FAIL resync_next_line: got %0d bad addr %0d err want 0 0", abad, nerr);
        end
        line_b(8, 4, 4, 8, abad, nerr, err_at, ndone, done_at);
        n_tests++;
        if (abad !== 0 || nerr !== 1 || err_at !== 9) begin
            n_fail++; $display("FAIL resync_at_line_end: got %0d bad addr %0d err at %0d want 0 1 at 9", abad, nerr, err_at);
        end
        line_b(8, 4, 0, -1, abad, nerr, err_at, ndone, done_at);
        n_tests++;
        if (abad !== 0 || nerr !== 0) begin
            n_fail++; $display("FAIL resync_restart_line: got %0d bad addr %0d err want 0 0", abad, nerr);
        end
    endtask

    initial begin
        test_reset();
        test_idle_active();
        test_frame_a();
        test_reset_mid();
        test_full_frame_b();
        test_resync_b();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
